avalon_seg_master_de1soc: RTL and testbench
===========================================

AVALON_SEG_MASTER_DE1SOC -- requirements
Module: avalon_seg_master_de1soc

Interface
REQ-001 SHALL have parameter DIGITS, default 6, number of display digits (one Avalon address per digit).
REQ-002 SHALL have parameter SKIP_UNCHANGED, default 1; when 1, digits equal to the last written value are not rewritten.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 value_i  input  4*DIGITS  hex value; nibble i goes to digit i (nibble 0 = LSB = address 0).
REQ-006 valid_i  input  1  value_i is valid.
REQ-007 ready_o  output  1  block can accept a value.
REQ-008 done_o  output  1  one-cycle pulse when an update sequence finishes.
REQ-009 avm_address_o  output  3  Avalon-MM master address (digit index).
REQ-010 avm_write_o  output  1  Avalon-MM write request.
REQ-011 avm_writedata_o  output  8  Avalon-MM write data.
REQ-012 avm_waitrequest_i  input  1  slave stall; tie to 0 for a slave without waitrequest.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, WRITE, DONE.
REQ-014 IDLE: ready_o=1; a value is accepted on a clk edge with valid_i&ready_o; value_i is captured into a buffer, idx=0, next state SCAN.
REQ-015 ready_o SHALL be 0 in every state except IDLE; valid_i outside IDLE SHALL be ignored.
REQ-016 SCAN (1 cycle): if SKIP_UNCHANGED=1, shadow_valid=1 and buffer nibble[idx]==shadow[idx], the digit is skipped; otherwise next state is WRITE.
REQ-017 After a skip: if idx==DIGITS-1, next state DONE; otherwise idx+1, remain in SCAN.
REQ-018 WRITE: avm_write_o=1, avm_address_o=idx, avm_writedata_o={4'h0, buffer nibble[idx]}.
REQ-019 These outputs SHALL be held stable while avm_waitrequest_i=1.
REQ-020 A write is accepted on the clk edge with avm_write_o=1 and avm_waitrequest_i=0; on acceptance shadow[idx] is updated.
REQ-021 After an accepted write: if idx==DIGITS-1, next state DONE; otherwise idx+1, next state SCAN.
REQ-022 DONE (1 cycle): done_o=1, shadow_valid=1, next state IDLE.
REQ-023 Latency: value accepted on edge N -> SCAN in cycle N+1 -> first avm_write_o in cycle N+2 when the digit is not skipped.
REQ-024 Cost per digit: 2 cycles min for a written digit, 1 cycle for a skipped digit; with no stalls a full 6-digit update is 12 cycles plus 1 DONE cycle.
REQ-025 avm_write_o SHALL be 0 outside WRITE; avm_address_o and avm_writedata_o are don't-care when avm_write_o=0 but SHALL be driven, never X.
REQ-026 idx SHALL never exceed DIGITS-1; no address >= DIGITS is ever issued.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, idx=0, buffer=0, shadow=0, shadow_valid=0, avm_write_o=0, done_o=0, avm_address_o=0, avm_writedata_o=0.
REQ-028 Reset mid-sequence SHALL abort the sequence with no further writes; the first sequence after reset writes all DIGITS digits.

Structure
REQ-029 A shared package seg_master_pkg SHALL hold the FSM state enum, DIGIT_W=4 and ADDR_W=3.
REQ-030 A single module is sufficient; no sub-module is required.

Verification
REQ-031 After reset: value_i=24'h012345, valid 1 cycle, waitrequest=0 -> writes addr0..5 with data 05,04,03,02,01,00; done_o pulses 13 cycles after accept.
REQ-032 Then 24'h012345 again -> no avm_write_o pulses; done_o after 6 SCAN cycles plus DONE.
REQ-033 Then 24'h012399 -> exactly two writes: addr0 data 09, addr1 data 09.
REQ-034 waitrequest=1 for 3 cycles during the addr2 write -> avm_write_o, address 2 and data stable for 4 cycles; that write is counted once.
REQ-035 rst_n pulled low during the addr3 write -> avm_write_o drops immediately (asynchronous); the next value produces all 6 writes.
REQ-036 valid_i held high with a new value during a sequence -> ready_o=0 and the value is not captured until IDLE, then accepted.

Source files
------------

// File: rtl/seg_master_pkg.sv
// Shared types and widths for the Avalon-MM seven-segment digit writer.
package seg_master_pkg;

  localparam int DIGIT_W = 4;
  localparam int ADDR_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/avalon_seg_master_de1soc.sv
// Pushes a hex value to a DE1-SoC seven-segment slave one digit per Avalon-MM address,
// optionally skipping digits whose last written value is unchanged.
module avalon_seg_master_de1soc
  import seg_master_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SKIP_UNCHANGED = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIGIT_W*DIGITS-1:0]   value_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic                        done_o,
  output logic [ADDR_W-1:0]           avm_address_o,
  output logic                        avm_write_o,
  output logic [7:0]                  avm_writedata_o,
  input  logic                        avm_waitrequest_i
);

  localparam int                VAL_W    = DIGIT_W * DIGITS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DIGITS - 1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      idx_q;
  logic [VAL_W-1:0]       buf_q;
  logic [VAL_W-1:0]       shadow_q;
  logic                   shadow_valid_q;

  logic                   accept;
  logic                   wr_accept;
  logic                   skip;
  logic                   last_digit;
  logic [DIGIT_W-1:0]     cur_nibble;

  function automatic logic [DIGIT_W-1:0] nibble_at(input logic [VAL_W-1:0] v,
                                                   input logic [ADDR_W-1:0] i);
    return v[i*DIGIT_W +: DIGIT_W];
  endfunction

  assign cur_nibble = nibble_at(buf_q, idx_q);
  assign last_digit = (idx_q == LAST_IDX);
  assign accept     = valid_i && (state_q == IDLE);
  assign wr_accept  = (state_q == WRITE) && !avm_waitrequest_i;
  // Shadow only becomes trustworthy after a full sequence has completed since reset.
  assign skip       = (SKIP_UNCHANGED != 0) && shadow_valid_q &&
                      (cur_nibble == nibble_at(shadow_q, idx_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (!skip) state_d = WRITE;
               else if (last_digit) state_d = DONE;
      WRITE:   if (wr_accept) state_d = last_digit ? DONE : SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o         = (state_q == IDLE);
    done_o          = (state_q == DONE);
    avm_write_o     = (state_q == WRITE);
    avm_address_o   = idx_q;
    avm_writedata_o = {4'h0, cur_nibble};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q          <= '0;
      buf_q          <= '0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          buf_q <= value_i;
          idx_q <= '0;
        end
        SCAN: if (skip && !last_digit) idx_q <= idx_q + 1'b1;
        WRITE: if (wr_accept) begin
          shadow_q[idx_q*DIGIT_W +: DIGIT_W] <= cur_nibble;
          if (!last_digit) idx_q <= idx_q + 1'b1;
        end
        DONE: shadow_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_seg_master_de1soc.sv
// Directed bench for avalon_seg_master_de1soc: full writes, skips, stalls, abort and back-pressure.
module tb_avalon_seg_master_de1soc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] value_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        done_o;
  logic [2:0]  avm_address_o;
  logic        avm_write_o;
  logic [7:0]  avm_writedata_o;
  logic        avm_waitrequest_i = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  int wr_addr [32];
  int wr_data [32];
  int wr_cnt, done_cyc, first_wr_cyc, hold_cnt, hold_bad, ready_hi_cnt;

  always #5 clk = ~clk;

  avalon_seg_master_de1soc #(.DIGITS(6), .SKIP_UNCHANGED(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .value_i           (value_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .done_o            (done_o),
    .avm_address_o     (avm_address_o),
    .avm_write_o       (avm_write_o),
    .avm_writedata_o   (avm_writedata_o),
    .avm_waitrequest_i (avm_waitrequest_i)
  );

  // Present a value for one edge; optionally leave valid high with a follow-up value.
  task automatic send(input logic [23:0] v, input bit keep, input logic [23:0] v2);
    @(posedge clk); #1;
    value_i = v;
    valid_i = 1'b1;
    @(negedge clk);
    n_assert++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: ready_o=%b required 1", ready_o);
    end
    @(posedge clk); #1;
    if (keep) value_i = v2;
    else valid_i = 1'b0;
  endtask

  // Record accepted writes until done_o, optionally stalling the write to stall_addr.
  task automatic capture(input int stall_addr, input int stalls);
    int left;
    logic [7:0] held;
    left = stalls;
    wr_cnt = 0; done_cyc = -1; first_wr_cyc = -1;
    hold_cnt = 0; hold_bad = 0; ready_hi_cnt = 0; held = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ready_o) ready_hi_cnt++;
      if (stalls > 0 && avm_write_o && int'(avm_address_o) == stall_addr) begin
        if (hold_cnt == 0) held = avm_writedata_o;
        else if (avm_writedata_o !== held) hold_bad++;
        hold_cnt++;
        if (left > 0) begin avm_waitrequest_i = 1'b1; left--; end
        else avm_waitrequest_i = 1'b0;
      end else begin
        avm_waitrequest_i = 1'b0;
      end
      if (avm_write_o && !avm_waitrequest_i && wr_cnt < 32) begin
        if (first_wr_cyc < 0) first_wr_cyc = c;
        wr_addr[wr_cnt] = int'(avm_address_o);
        wr_data[wr_cnt] = int'(avm_writedata_o);
        wr_cnt++;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
    end
    avm_waitrequest_i = 1'b0;
    n_assert++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL capture_timeout: done_o not seen within 60 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    n_assert++;
    if ({ready_o, done_o, avm_write_o, avm_address_o, avm_writedata_o} !== {1'b1, 1'b0, 1'b0, 3'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b done=%b wr=%b addr=%0d data=%h required 1 0 0 0 00",
               ready_o, done_o, avm_write_o, avm_address_o, avm_writedata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_write();
    send(24'h012345, 1'b0, 24'h0);
    capture(-1, 0);
    n_assert++;
    if (wr_cnt !== 6) begin n_fail++; $display("FAIL full_count: got %0d required 6", wr_cnt); end
    for (int i = 0; i < 6 && i < wr_cnt; i++) begin
      n_assert++;
      if (wr_addr[i] !== i || wr_data[i] !== 5 - i) begin
        n_fail++;
        $display("FAIL full_write%0d: addr=%0d data=%0h required addr=%0d data=%0h",
                 i, wr_addr[i], wr_data[i], i, 5 - i);
      end
    end
    n_assert++;
    if (first_wr_cyc !== 2) begin n_fail++; $display("FAIL full_latency: first write cycle %0d required 2", first_wr_cyc); end
    n_assert++;
    if (done_cyc !== 13) begin n_fail++; $display("FAIL full_done: done cycle %0d required 13", done_cyc); end
  endtask

  task automatic test_skip_all();
    send(24'h012345, 1'b0, 24'h0);
    capture(-1, 0);
    n_assert++;
    if (wr_cnt !== 0) begin n_fail++; $display("FAIL skip_count: got %0d required 0", wr_cnt); end
    n_assert++;
    if (done_cyc !== 7) begin n_fail++; $display("FAIL skip_done: done cycle %0d required 7", done_cyc); end
  endtask

  task automatic test_partial();
    send(24'h012399, 1'b0, 24'h0);
    capture(-1, 0);
    n_assert++;
    if (wr_cnt !== 2) begin n_fail++; $display("FAIL partial_count: got %0d required 2", wr_cnt); end
    for (int i = 0; i < 2 && i < wr_cnt; i++) begin
      n_assert++;
      if (wr_addr[i] !== i || wr_data[i] !== 9) begin
        n_fail++;
        $display("FAIL partial_write%0d: addr=%0d data=%0h required addr=%0d data=9", i, wr_addr[i], wr_data[i], i);
      end
    end
    n_assert++;
    if (done_cyc !== 9) begin n_fail++; $display("FAIL partial_done: done cycle %0d required 9", done_cyc); end
  endtask

  task automatic test_waitrequest();
    int a2;
    send(24'h777777, 1'b0, 24'h0);
    capture(2, 3);
    a2 = 0;
    for (int i = 0; i < wr_cnt; i++) if (wr_addr[i] == 2) a2++;
    n_assert++;
    if (wr_cnt !== 6) begin n_fail++; $display("FAIL stall_count: got %0d required 6", wr_cnt); end
    n_assert++;
    if (a2 !== 1) begin n_fail++; $display("FAIL stall_once: addr2 accepted %0d times required 1", a2); end
    n_assert++;
    if (hold_cnt !== 4 || hold_bad !== 0) begin
      n_fail++;
      $display("FAIL stall_hold: held %0d cycles (%0d changed) required 4 (0)", hold_cnt, hold_bad);
    end
    for (int i = 0; i < 6 && i < wr_cnt; i++) begin
      n_assert++;
      if (wr_addr[i] !== i || wr_data[i] !== 7) begin
        n_fail++;
        $display("FAIL stall_write%0d: addr=%0d data=%0h required addr=%0d data=7", i, wr_addr[i], wr_data[i], i);
      end
    end
    n_assert++;
    if (done_cyc !== 16) begin n_fail++; $display("FAIL stall_done: done cycle %0d required 16", done_cyc); end
  endtask

  task automatic test_reset_abort();
    int seen, stray;
    seen = 0; stray = 0;
    send(24'h000000, 1'b0, 24'h0);
    for (int c = 0; c < 30 && seen == 0; c++) begin
      @(negedge clk);
      if (avm_write_o && avm_address_o == 3'd3) seen = 1;
    end
    n_assert++;
    if (seen !== 1) begin n_fail++; $display("FAIL abort_reach: addr3 write seen=%0d required 1", seen); end
    #1 rst_n = 1'b0;
    #1;
    n_assert++;
    if (avm_write_o !== 1'b0 || ready_o !== 1'b1 || avm_address_o !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_async: wr=%b rdy=%b addr=%0d required 0 1 0", avm_write_o, ready_o, avm_address_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (avm_write_o) stray++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (avm_write_o || done_o) stray++;
    end
    n_assert++;
    if (stray !== 0) begin n_fail++; $display("FAIL abort_quiet: %0d stray cycles required 0", stray); end
    send(24'h000000, 1'b0, 24'h0);
    capture(-1, 0);
    n_assert++;
    if (wr_cnt !== 6) begin n_fail++; $display("FAIL abort_rewrite: got %0d writes required 6", wr_cnt); end
    for (int i = 0; i < 6 && i < wr_cnt; i++) begin
      n_assert++;
      if (wr_addr[i] !== i || wr_data[i] !== 0) begin
        n_fail++;
        $display("FAIL abort_write%0d: addr=%0d data=%0h required addr=%0d data=0", i, wr_addr[i], wr_data[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(24'h111111, 1'b1, 24'h222222);
    capture(-1, 0);
    n_assert++;
    if (ready_hi_cnt !== 0) begin n_fail++; $display("FAIL b2b_busy_ready: ready high %0d cycles required 0", ready_hi_cnt); end
    n_assert++;
    if (wr_cnt !== 6) begin n_fail++; $display("FAIL b2b_first_count: got %0d required 6", wr_cnt); end
    for (int i = 0; i < 6 && i < wr_cnt; i++) begin
      n_assert++;
      if (wr_data[i] !== 1) begin n_fail++; $display("FAIL b2b_first%0d: data=%0h required 1", i, wr_data[i]); end
    end
    @(negedge clk);
    n_assert++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready: ready_o=%b required 1", ready_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    capture(-1, 0);
    n_assert++;
    if (wr_cnt !== 6 || done_cyc !== 13) begin
      n_fail++;
      $display("FAIL b2b_second: %0d writes done cycle %0d required 6 and 13", wr_cnt, done_cyc);
    end
    for (int i = 0; i < 6 && i < wr_cnt; i++) begin
      n_assert++;
      if (wr_addr[i] !== i || wr_data[i] !== 2) begin
        n_fail++;
        $display("FAIL b2b_second%0d: addr=%0d data=%0h required addr=%0d data=2", i, wr_addr[i], wr_data[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_skip_all();
    test_partial();
    test_waitrequest();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
